framebuffer_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM between display scan-out and a pixel writer.

---
 rtl/framebuffer_arbiter_if.sv | 38 +++
 rtl/framebuffer_arbiter.sv | 141 ++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_arbiter_if.sv
// rtl/framebuffer_arbiter_if.sv - framebuffer arbiter bus bundle (scan-out, writer, clear, RAM)
interface framebuffer_arbiter_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                          disp_rd_en;
    logic [ADDR_WIDTH-1:0]         disp_addr;
    logic [DATA_WIDTH-1:0]         disp_pixel;
    logic                          disp_pixel_valid;
    logic                          wr_valid;
    logic                          wr_ready;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          clear_start;
    logic [DATA_WIDTH-1:0]         clear_color;
    logic                          busy;
    logic                          clear_done;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          mem_we;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    modport slave (
        input  disp_rd_en, disp_addr, wr_valid, wr_addr, wr_data,
               clear_start, clear_color, mem_rdata,
        output disp_pixel, disp_pixel_valid, wr_ready, busy, clear_done,
               fifo_level, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output disp_rd_en, disp_addr, wr_valid, wr_addr, wr_data,
               clear_start, clear_color, mem_rdata,
        input  disp_pixel, disp_pixel_valid, wr_ready, busy, clear_done,
               fifo_level, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - single-port framebuffer arbiter: scan-out, buffered writer, clear engine
module framebuffer_arbiter #(
    parameter int MEM_SIZE   = 76800,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    framebuffer_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic [DATA_WIDTH-1:0]  clr_color;
    logic                   busy_q;
    logic                   done_q;
    logic                   disp_valid_q;

    logic [ADDR_WIDTH-1:0]  fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [LVL_W-1:0]       level;

    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   clr_grant;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic                   head_in_range;

    assign fifo_empty    = (level == '0);
    assign head_addr     = fifo_addr[rd_ptr];
    // Widen by one bit so MEM_SIZE == 2**ADDR_WIDTH still compares correctly.
    assign head_in_range = ({1'b0, head_addr} < (ADDR_WIDTH+1)'(MEM_SIZE));

    // Writer is only admitted while idle so queued pixels cannot straddle a fill.
    assign bus.wr_ready  = (state == IDLE) && (level < LVL_W'(FIFO_DEPTH));
    assign push          = bus.wr_valid && bus.wr_ready;

    assign bus.disp_pixel       = bus.mem_rdata;
    assign bus.disp_pixel_valid = disp_valid_q;
    assign bus.busy             = busy_q;
    assign bus.clear_done       = done_q;
    assign bus.fifo_level       = level;

    // RAM grant mux: scan-out first, then clear engine, then FIFO drain.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        pop           = 1'b0;
        clr_grant     = 1'b0;
        if (bus.disp_rd_en) begin
            bus.mem_addr = bus.disp_addr;
        end else if (state == CLEAR) begin
            bus.mem_addr  = clr_cnt;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = clr_color;
            clr_grant     = 1'b1;
        end else if (!fifo_empty) begin
            // Out-of-range entries are still popped, just never written.
            pop           = 1'b1;
            bus.mem_addr  = head_addr;
            bus.mem_we    = head_in_range;
            bus.mem_wdata = fifo_data[rd_ptr];
        end
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy; a reset discards anything still queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Control FSM: IDLE -> DRAIN (flush queued writes) -> CLEAR (fill) -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            clr_color    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            disp_valid_q <= bus.disp_rd_en;
            done_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear_start) begin
                        state     <= DRAIN;
                        busy_q    <= 1'b1;
                        clr_color <= bus.clear_color;
                        clr_cnt   <= '0;
                    end
                end
                DRAIN: begin
                    // No pushes here, so the FIFO empties once the last entry pops.
                    if (fifo_empty || (pop && level == LVL_W'(1))) state <= CLEAR;
                end
                CLEAR: begin
                    if (clr_grant) begin
                        if (clr_cnt == ADDR_WIDTH'(MEM_SIZE - 1)) begin
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            clr_cnt <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - scoreboard testbench for framebuffer_arbiter
module tb_framebuffer_arbiter;
    localparam int MEM_SIZE = 64;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int FD = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    framebuffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

    framebuffer_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] ram    [2**AW];
    logic [DW-1:0] shadow [2**AW];
    wr_t           exp_wr_q [$];
    logic [DW-1:0] exp_rd_q [$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    function automatic logic [DW-1:0] pat(int i);
        return DW'(i * 7 + 3);
    endfunction

    // RAM model: synchronous write, registered read.
    initial begin
        for (int i = 0; i < 2**AW; i++) ram[i] = (i == 5) ? 8'h3C : pat(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic monitor();
        wr_t e;
        logic [DW-1:0] r;
        if (!reset) return;
        if (bus.mem_we) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_wr_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write_order got=%0d/%h exp=%0d/%h", bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                end
                shadow[e.addr] = e.data;
            end
        end
        if (bus.disp_rd_en) begin
            checks++;
            if (bus.mem_we !== 1'b0 || bus.mem_addr !== bus.disp_addr) begin
                errors++;
                $display("FAIL disp_priority we=%b addr=%0d exp we=0 addr=%0d", bus.mem_we, bus.mem_addr, bus.disp_addr);
            end
        end
        if (bus.disp_pixel_valid) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel got=%h", bus.disp_pixel);
            end else begin
                r = exp_rd_q.pop_front();
                if (bus.disp_pixel !== r) begin
                    errors++;
                    $display("FAIL disp_pixel got=%h exp=%h", bus.disp_pixel, r);
                end
            end
        end
        if (bus.clear_done) done_cnt++;
    endtask

    task automatic at_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        at_neg();
        to_pos();
    endtask

    task automatic idle_inputs();
        bus.disp_rd_en = 1'b0; bus.disp_addr = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clear_start = 1'b0; bus.clear_color = '0;
    endtask

    task automatic push_read(int a);
        bus.disp_rd_en = 1'b1;
        bus.disp_addr = AW'(a);
        exp_rd_q.push_back(shadow[a]);
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (bus.fifo_level != 0 && n < 40) begin tick(); n++; end
        tick(); tick();
        checks++;
        if (bus.fifo_level !== '0) begin errors++; $display("FAIL %s_drain level=%0d exp=0", name, bus.fifo_level); end
        checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_queues pending wr=%0d rd=%0d exp=0/0", name, exp_wr_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic start_clear(logic [DW-1:0] color);
        bus.clear_start = 1'b1;
        bus.clear_color = color;
        for (int i = 0; i < MEM_SIZE; i++) exp_wr_q.push_back({AW'(i), color});
    endtask

    task automatic wait_done(string name);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 400) begin
            at_neg();
            if (bus.clear_done) seen = 1;
            to_pos();
            n++;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s_done_timeout got=0 exp=1", name); end
    endtask

    task automatic check_fill(string name, logic [DW-1:0] color, int d0);
        int bad = 0;
        tick(); tick();
        for (int i = 0; i < MEM_SIZE; i++) if (ram[i] !== color) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s_fill bad_words=%0d exp=0", name, bad); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_pulses got=%0d exp=1", name, done_cnt - d0); end
        checks++;
        if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1) begin
            errors++; $display("FAIL %s_after busy=%b wr_ready=%b exp=0/1", name, bus.busy, bus.wr_ready);
        end
        checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++; $display("FAIL %s_queues wr=%0d rd=%0d exp=0/0", name, exp_wr_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int i = 0; i < 2**AW; i++) shadow[i] = (i == 5) ? 8'h3C : pat(i);
        reset = 1'b0;
        to_pos(); to_pos();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.clear_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.clear_done); end
        checks++; if (bus.disp_pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.disp_pixel_valid); end
        checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0) begin
            errors++; $display("FAIL reset_mem we=%b addr=%0d exp=0/0", bus.mem_we, bus.mem_addr);
        end
        reset = 1'b1;
        to_pos();
    endtask

    task automatic test_display_priority();
        int addrs [4] = '{5, 6, 7, 5};
        for (int i = 0; i < 4; i++) begin
            push_read(addrs[i]);
            bus.wr_valid = 1'b1; bus.wr_addr = AW'(40 + i); bus.wr_data = DW'(8'hC0 + i);
            at_neg();
            checks++;
            if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL disp_wr_ready got=%b exp=1", bus.wr_ready); end
            exp_wr_q.push_back({AW'(40 + i), DW'(8'hC0 + i)});
            if (i == 1) begin
                checks++;
                if (bus.disp_pixel_valid !== 1'b1 || bus.disp_pixel !== 8'h3C) begin
                    errors++; $display("FAIL disp_first_pixel valid=%b data=%h exp=1/3c", bus.disp_pixel_valid, bus.disp_pixel);
                end
            end
            to_pos();
        end
        idle_inputs();
        wait_drain("disp");
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 9; i++) begin
            push_read(8 + i);
            bus.wr_valid = 1'b1; bus.wr_addr = AW'(24 + i); bus.wr_data = DW'(8'h10 + i);
            at_neg();
            checks++;
            if (bus.wr_ready !== (i < FD)) begin errors++; $display("FAIL full_wr_ready i=%0d got=%b exp=%b", i, bus.wr_ready, i < FD); end
            checks++;
            if (bus.fifo_level !== 4'(i)) begin errors++; $display("FAIL full_level i=%0d got=%0d exp=%0d", i, bus.fifo_level, i); end
            if (i < FD) exp_wr_q.push_back({AW'(24 + i), DW'(8'h10 + i)});
            to_pos();
        end
        idle_inputs();
        wait_drain("full");
    endtask

    task automatic test_clear_basic();
        int d0;
        for (int i = 0; i < 3; i++) begin
            push_read(0);
            bus.wr_valid = 1'b1; bus.wr_addr = AW'(50 + i); bus.wr_data = DW'(8'hE0 + i);
            at_neg();
            checks++;
            if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL clr_wr_ready got=%b exp=1", bus.wr_ready); end
            exp_wr_q.push_back({AW'(50 + i), DW'(8'hE0 + i)});
            to_pos();
        end
        idle_inputs();
        d0 = done_cnt;
        start_clear(8'hAA);
        tick();
        bus.clear_start = 1'b0;
        at_neg();
        checks++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
            errors++; $display("FAIL clr_busy busy=%b wr_ready=%b exp=1/0", bus.busy, bus.wr_ready);
        end
        to_pos();
        wait_done("clr");
        check_fill("clr", 8'hAA, d0);
    endtask

    task automatic test_clear_during_scanout();
        int d0 = done_cnt;
        int c = 0;
        bit seen = 0;
        start_clear(8'h55);
        tick();
        bus.clear_start = 1'b0;
        while (!seen && c < 600) begin
            if ((c / 4) % 2 == 0) push_read(c % MEM_SIZE);
            else bus.disp_rd_en = 1'b0;
            at_neg();
            if (bus.clear_done) seen = 1;
            to_pos();
            c++;
        end
        idle_inputs();
        checks++;
        if (!seen) begin errors++; $display("FAIL scan_done_timeout got=0 exp=1"); end
        check_fill("scan", 8'h55, d0);
    endtask

    task automatic test_out_of_range();
        bus.wr_valid = 1'b1; bus.wr_addr = AW'(MEM_SIZE); bus.wr_data = 8'h11;
        tick();
        bus.wr_addr = AW'(7); bus.wr_data = 8'h22;
        exp_wr_q.push_back({AW'(7), 8'h22});
        at_neg();
        checks++;
        if (bus.mem_addr !== AW'(MEM_SIZE) || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL oor_pop addr=%0d we=%b exp=%0d/0", bus.mem_addr, bus.mem_we, MEM_SIZE);
        end
        checks++;
        if (bus.fifo_level !== 4'd1) begin errors++; $display("FAIL oor_level got=%0d exp=1", bus.fifo_level); end
        to_pos();
        idle_inputs();
        wait_drain("oor");
        checks++;
        if (ram[7] !== 8'h22 || ram[MEM_SIZE] !== pat(MEM_SIZE)) begin
            errors++; $display("FAIL oor_ram ram7=%h ram64=%h exp=22/%h", ram[7], ram[MEM_SIZE], pat(MEM_SIZE));
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        int d0;
        start_clear(8'h99);
        tick();
        bus.clear_start = 1'b0;
        forever begin
            at_neg();
            if (exp_wr_q.size() <= MEM_SIZE - 40 || n >= 200) break;
            to_pos();
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL rst_reach_40 pending=%0d exp<=%0d", exp_wr_q.size(), MEM_SIZE - 40); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.fifo_level !== '0 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL rst_abort busy=%b level=%0d we=%b exp=0/0/0", bus.busy, bus.fifo_level, bus.mem_we);
        end
        exp_wr_q.delete();
        to_pos(); tick();
        reset = 1'b1;
        tick();
        d0 = done_cnt;
        start_clear(8'h33);
        tick();
        bus.clear_start = 1'b0;
        wait_done("rst");
        check_fill("rst", 8'h33, d0);
    endtask

    initial begin
        test_reset();
        test_display_priority();
        test_fifo_full();
        test_clear_basic();
        test_clear_during_scanout();
        test_out_of_range();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
